nexys_starship_rooms: RTL and testbench

Parametrised multi-room damage/repair controller for Nexys Starship; generalises the single top-room repair FSM to NUM_ROOMS independent rooms with configurable combo width, a per-room repair deadline and wrong-attempt tracking. Sits between the game-control FSM (play/gameover), the random generator (break events, combo values) and the player input path (room select, hex combo, submit). All outputs are registered and drive the display/VGA and game-over logic.

---
 rtl/nexys_starship_rooms.sv | 215 +++++++++++++++++++++
 tb/tb_nexys_starship_rooms.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_rooms.sv
// nexys_starship_rooms
// ---------------------------------------------------------------------------
// Multi-room damage/repair controller for Nexys Starship. Each of NUM_ROOMS
// rooms runs its own one-hot FSM (INIT -> WORKING -> REPAIR -> WORKING ...).
// A break event latches a repair combo and arms a per-room deadline. The
// player repairs a room by submitting the matching combo. A deadline that
// runs out raises a sticky failure flag and records the first failing room.
//
// Optional feature: define REPAIR_BYPASS_EN to enable the force_fix_i debug
// repair. When it is undefined, force_fix_i is accepted but ignored.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_ni         synchronous, active-low reset
//   play_flag_i      level, game running (INIT -> WORKING)
//   gameover_ctrl_i  level, forces every room back to INIT and clears counters
//   break_req_i      per-room single-cycle break event
//   random_hex_i     combo latched into rooms that break this cycle
//   sel_room_i       room targeted by submit_i / force_fix_i
//   hex_combo_i      player-entered combo
//   submit_i         single-cycle pulse, check hex_combo_i against sel_room_i
//   force_fix_i      single-cycle pulse, debug repair (REPAIR_BYPASS_EN only)
//   room_state_o     one-hot {REPAIR,WORKING,INIT} per room, room i at [3i+2:3i]
//   room_broken_o    per-room broken flag
//   repair_combo_o   latched combo per room, room i at [COMBO_W*i +: COMBO_W]
//   broken_count_o   number of rooms in REPAIR (one cycle behind room_state_o)
//   miss_count_o     saturating count of wrong submits
//   room_failed_o    sticky, a repair deadline expired
//   fail_room_o      index of the first room that failed
//
// Pulse semantics: submit_i and force_fix_i carry no handshake. Each cycle
// they are high is one independent request, acted on at that rising edge.
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module nexys_starship_rooms #(
  parameter int                    NUM_ROOMS     = 4,
  parameter int                    COMBO_W       = 4,
  parameter int                    DEADLINE_W    = 16,
  parameter logic [DEADLINE_W-1:0] REPAIR_CYCLES = 16'd50000
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         play_flag_i,
  input  logic                         gameover_ctrl_i,
  input  logic [NUM_ROOMS-1:0]         break_req_i,
  input  logic [COMBO_W-1:0]           random_hex_i,
  input  logic [2:0]                   sel_room_i,
  input  logic [COMBO_W-1:0]           hex_combo_i,
  input  logic                         submit_i,
  input  logic                         force_fix_i,
  output logic [3*NUM_ROOMS-1:0]       room_state_o,
  output logic [NUM_ROOMS-1:0]         room_broken_o,
  output logic [COMBO_W*NUM_ROOMS-1:0] repair_combo_o,
  output logic [3:0]                   broken_count_o,
  output logic [7:0]                   miss_count_o,
  output logic                         room_failed_o,
  output logic [2:0]                   fail_room_o
);

  typedef enum logic [2:0] {
    INIT    = 3'b001,
    WORKING = 3'b010,
    REPAIR  = 3'b100
  } room_st_e;

  room_st_e              state_q    [NUM_ROOMS];
  room_st_e              state_d    [NUM_ROOMS];
  logic                  broken_q   [NUM_ROOMS];
  logic                  broken_d   [NUM_ROOMS];
  logic [COMBO_W-1:0]    combo_q    [NUM_ROOMS];
  logic [COMBO_W-1:0]    combo_d    [NUM_ROOMS];
  logic [DEADLINE_W-1:0] deadline_q [NUM_ROOMS];
  logic [DEADLINE_W-1:0] deadline_d [NUM_ROOMS];

  logic [3:0] broken_count_q, broken_count_d;
  logic [7:0] miss_count_q,   miss_count_d;
  logic       room_failed_q,  room_failed_d;
  logic [2:0] fail_room_q,    fail_room_d;

`ifndef REPAIR_BYPASS_EN
  // The port stays present so both builds share one pinout.
  logic unused_force_fix;
  assign unused_force_fix = force_fix_i;
`endif

  // Next-state logic for all rooms plus the shared counters.
  always_comb begin
    logic sel_hit;
    logic fix;
    logic wrong;
    logic fail_taken;

    sel_hit    = 1'b0;
    fix        = 1'b0;
    wrong      = 1'b0;
    fail_taken = room_failed_q;

    miss_count_d   = miss_count_q;
    room_failed_d  = room_failed_q;
    fail_room_d    = fail_room_q;
    broken_count_d = 4'd0;

    for (int i = 0; i < NUM_ROOMS; i++) begin
      state_d[i]    = state_q[i];
      broken_d[i]   = broken_q[i];
      combo_d[i]    = combo_q[i];
      deadline_d[i] = deadline_q[i];
      if (state_q[i] == REPAIR) broken_count_d = broken_count_d + 4'd1;
    end

    if (gameover_ctrl_i) begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        state_d[i]    = INIT;
        broken_d[i]   = 1'b0;
        combo_d[i]    = '0;
        deadline_d[i] = '0;
      end
      broken_count_d = 4'd0;
      miss_count_d   = 8'd0;
      room_failed_d  = 1'b0;
      fail_room_d    = 3'd0;
    end else begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        // sel_room_i values at or above NUM_ROOMS match no room.
        sel_hit = (sel_room_i == 3'(i));
        unique case (state_q[i])
          INIT: begin
            if (play_flag_i) state_d[i] = WORKING;
          end
          WORKING: begin
            if (break_req_i[i]) begin
              state_d[i]    = REPAIR;
              broken_d[i]   = 1'b1;
              combo_d[i]    = random_hex_i;
              deadline_d[i] = REPAIR_CYCLES;
            end
          end
          REPAIR: begin
            fix   = sel_hit && submit_i && (hex_combo_i == combo_q[i]);
            wrong = sel_hit && submit_i && (hex_combo_i != combo_q[i]);
`ifdef REPAIR_BYPASS_EN
            // A forced fix overrides a wrong combo submitted the same cycle.
            if (sel_hit && force_fix_i) begin
              fix   = 1'b1;
              wrong = 1'b0;
            end
`endif
            if (fix) begin
              // A repair wins over a deadline that expires this same cycle.
              state_d[i]    = WORKING;
              broken_d[i]   = 1'b0;
              deadline_d[i] = '0;
            end else begin
              if (wrong && (miss_count_q != 8'hFF)) miss_count_d = miss_count_q + 8'd1;
              // The counter stops at 0 after expiry. The failure flag is sticky.
              if (deadline_q[i] != '0) deadline_d[i] = deadline_q[i] - DEADLINE_W'(1);
              if (deadline_q[i] == DEADLINE_W'(1)) begin
                room_failed_d = 1'b1;
                if (!fail_taken) begin
                  fail_room_d = 3'(i);
                  fail_taken  = 1'b1;
                end
              end
            end
          end
          default: begin
            // An illegal encoding recovers to INIT.
            state_d[i]    = INIT;
            broken_d[i]   = 1'b0;
            combo_d[i]    = '0;
            deadline_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        state_q[i]    <= INIT;
        broken_q[i]   <= 1'b0;
        combo_q[i]    <= '0;
        deadline_q[i] <= '0;
      end
      broken_count_q <= 4'd0;
      miss_count_q   <= 8'd0;
      room_failed_q  <= 1'b0;
      fail_room_q    <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        state_q[i]    <= state_d[i];
        broken_q[i]   <= broken_d[i];
        combo_q[i]    <= combo_d[i];
        deadline_q[i] <= deadline_d[i];
      end
      broken_count_q <= broken_count_d;
      miss_count_q   <= miss_count_d;
      room_failed_q  <= room_failed_d;
      fail_room_q    <= fail_room_d;
    end
  end

  for (genvar g = 0; g < NUM_ROOMS; g++) begin : g_out
    assign room_state_o[3*g +: 3]             = state_q[g];
    assign room_broken_o[g]                   = broken_q[g];
    assign repair_combo_o[COMBO_W*g +: COMBO_W] = combo_q[g];
  end

  assign broken_count_o = broken_count_q;
  assign miss_count_o   = miss_count_q;
  assign room_failed_o  = room_failed_q;
  assign fail_room_o    = fail_room_q;

endmodule

// File: tb/tb_nexys_starship_rooms.sv
// tb_nexys_starship_rooms
// Directed bench for nexys_starship_rooms with 4 rooms, 4-bit combos and an
// 8-cycle repair deadline. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point, before any input changes.
module tb_nexys_starship_rooms;

  localparam int NR = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            play_flag;
  logic            gameover_ctrl;
  logic [NR-1:0]   break_req;
  logic [CW-1:0]   random_hex;
  logic [2:0]      sel_room;
  logic [CW-1:0]   hex_combo;
  logic            submit;
  logic            force_fix;
  logic [3*NR-1:0] room_state;
  logic [NR-1:0]   room_broken;
  logic [CW*NR-1:0] repair_combo;
  logic [3:0]      broken_count;
  logic [7:0]      miss_count;
  logic            room_failed;
  logic [2:0]      fail_room;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  nexys_starship_rooms #(
    .NUM_ROOMS    (NR),
    .COMBO_W      (CW),
    .DEADLINE_W   (16),
    .REPAIR_CYCLES(16'd8)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .play_flag_i    (play_flag),
    .gameover_ctrl_i(gameover_ctrl),
    .break_req_i    (break_req),
    .random_hex_i   (random_hex),
    .sel_room_i     (sel_room),
    .hex_combo_i    (hex_combo),
    .submit_i       (submit),
    .force_fix_i    (force_fix),
    .room_state_o   (room_state),
    .room_broken_o  (room_broken),
    .repair_combo_o (repair_combo),
    .broken_count_o (broken_count),
    .miss_count_o   (miss_count),
    .room_failed_o  (room_failed),
    .fail_room_o    (fail_room)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_break(input logic [NR-1:0] mask, input logic [CW-1:0] hex);
    break_req  = mask;
    random_hex = hex;
    step();
    break_req  = '0;
  endtask

  task automatic do_submit(input logic [2:0] room, input logic [CW-1:0] hex);
    sel_room  = room;
    hex_combo = hex;
    submit    = 1'b1;
    step();
    submit    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; play_flag = 1'b0; gameover_ctrl = 1'b0; break_req = '0;
    random_hex = '0; sel_room = '0; hex_combo = '0; submit = 1'b0; force_fix = 1'b0;
    step(2);
    check("rst_state", room_state, 12'h249);
    check("rst_broken", room_broken, 4'h0);
    check("rst_miss", miss_count, 8'd0);
    check("rst_failed", room_failed, 1'b0);

    reset_n = 1'b1; play_flag = 1'b1;
    step();
    check("play_state", room_state, 12'h492);
    check("play_count", broken_count, 4'd0);

    // Break rooms 0 and 2 with combo A.
    do_break(4'b0101, 4'hA);
    check("brk_state", room_state, 12'h514);
    check("brk_broken", room_broken, 4'b0101);
    check("brk_combo", repair_combo, 16'h0A0A);
    check("brk_count_lag", broken_count, 4'd0);
    step();
    check("brk_count", broken_count, 4'd2);

    // A second break on a room already in REPAIR keeps its combo.
    do_break(4'b0001, 4'h3);
    check("rebrk_combo", repair_combo, 16'h0A0A);
    check("rebrk_state", room_state, 12'h514);

    do_submit(3'd2, 4'h5);
    check("wrong_miss", miss_count, 8'd1);
    check("wrong_state", room_state, 12'h514);
    do_submit(3'd2, 4'hA);
    check("fix2_state", room_state, 12'h494);
    check("fix2_broken", room_broken, 4'b0001);
    do_submit(3'd0, 4'hA);
    check("fix0_state", room_state, 12'h492);
    check("fix0_failed", room_failed, 1'b0);

    // Submits to a WORKING room or to an out-of-range room are ignored.
    do_submit(3'd1, 4'h7);
    do_submit(3'd5, 4'h7);
    check("noeff_miss", miss_count, 8'd1);
    check("noeff_state", room_state, 12'h492);

    // Repair one cycle early (edge n+7) and on the expiry cycle (edge n+8).
    do_break(4'b0010, 4'h7);
    step(6);
    do_submit(3'd1, 4'h7);
    check("early_fix_state", room_state, 12'h492);
    step(3);
    check("early_fix_failed", room_failed, 1'b0);
    do_break(4'b0010, 4'h7);
    step(7);
    do_submit(3'd1, 4'h7);
    check("edge_fix_state", room_state, 12'h492);
    check("edge_fix_failed", room_failed, 1'b0);

    // Rooms 1 and 3 expire together, so the lower index is reported.
    do_break(4'b1010, 4'h9);
    step(7);
    check("pre_expire", room_failed, 1'b0);
    step();
    check("expire_failed", room_failed, 1'b1);
    check("expire_room", fail_room, 3'd1);
    check("expire_state", room_state, 12'h8A2);
    check("expire_count", broken_count, 4'd2);

    // Miss counter saturates at 255.
    sel_room = 3'd1; hex_combo = 4'h0; submit = 1'b1;
    step(260);
    submit = 1'b0;
    check("miss_sat", miss_count, 8'd255);

    // Debug repair of room 1.
    sel_room = 3'd1; force_fix = 1'b1;
    step();
    force_fix = 1'b0;
`ifdef REPAIR_BYPASS_EN
    check("force_state", room_state, 12'h892);
`else
    check("force_state", room_state, 12'h8A2);
`endif
    check("force_miss", miss_count, 8'd255);

    // Game over clears everything.
    gameover_ctrl = 1'b1;
    step();
    gameover_ctrl = 1'b0;
    check("go_state", room_state, 12'h249);
    check("go_combo", repair_combo, 16'h0000);
    check("go_broken", room_broken, 4'h0);
    check("go_miss", miss_count, 8'd0);
    check("go_failed", room_failed, 1'b0);
    check("go_fail_room", fail_room, 3'd0);
    check("go_count", broken_count, 4'd0);
    step();
    check("go_replay", room_state, 12'h492);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
